// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch port and a
// load/store port. Only one access is outstanding at a time. Every access is
// followed by one idle bubble cycle before the next grant can be issued.
// A granted access that sees no m_ready for TIMEOUT wait cycles is aborted
// with an err pulse.
// Optional feature: define MEM_ARB_RR_EN to arbitrate between simultaneous
// requests round-robin. Without it, data requests always win.
//
// state  | meaning
// IDLE   | no access outstanding; pick a winner from i_req/d_req
// BUSY_I | fetch access on the memory port, waiting for m_ready
// BUSY_D | load/store access on the memory port, waiting for m_ready
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic        i_err,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_op,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [2:0]  m_op,
   input  logic        m_ready,
   input  logic [31:0] m_rdata
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
   localparam logic [2:0] OP_WORD     = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] wait_cnt;
   logic       pick_i;
   logic       pick_d;
   logic       timeout_hit;
   logic       finish;

`ifdef MEM_ARB_RR_EN
   // 1: the fetch port wins the next tie, 0: the data port wins it
   logic       rr_inst_next;

   // Winner selection with alternating priority on a tie
   always_comb begin
      pick_i = 1'b0;
      pick_d = 1'b0;
      if (d_req && i_req) begin
         pick_i = rr_inst_next;
         pick_d = ~rr_inst_next;
      end else if (d_req) begin
         pick_d = 1'b1;
      end else if (i_req) begin
         pick_i = 1'b1;
      end
   end

   // Point the tie-breaker at the other port after every grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_inst_next <= 1'b0;
      end else if (state == IDLE) begin
         if (pick_d) begin
            rr_inst_next <= 1'b1;
         end else if (pick_i) begin
            rr_inst_next <= 1'b0;
         end
      end
   end
`else
   // Winner selection with fixed data-over-fetch priority
   always_comb begin
      pick_i = 1'b0;
      pick_d = 1'b0;
      if (d_req) begin
         pick_d = 1'b1;
      end else if (i_req) begin
         pick_i = 1'b1;
      end
   end
`endif

   // Completion beats timeout when both land in the same cycle
   assign timeout_hit = !m_ready && (wait_cnt == TIMEOUT_CNT);
   assign finish      = m_ready || (wait_cnt == TIMEOUT_CNT);

   // Response pulses are same-cycle with m_ready, so they decode the state
   assign i_rvalid = (state == BUSY_I) && m_ready;
   assign i_err    = (state == BUSY_I) && timeout_hit;
   assign i_rdata  = i_rvalid ? m_rdata : 32'h0;
   assign d_rvalid = (state == BUSY_D) && m_ready;
   assign d_err    = (state == BUSY_D) && timeout_hit;
   assign d_rdata  = (d_rvalid && !m_we) ? m_rdata : 32'h0;

   // Sequencer: grant, drive the memory port, wait for completion or timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= 8'd0;
         i_gnt    <= 1'b0;
         d_gnt    <= 1'b0;
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= 32'h0;
         m_wdata  <= 32'h0;
         m_op     <= 3'b000;
      end else begin
         i_gnt <= 1'b0;
         d_gnt <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_d) begin
                  state    <= BUSY_D;
                  wait_cnt <= 8'd0;
                  d_gnt    <= 1'b1;
                  m_req    <= 1'b1;
                  m_we     <= d_we;
                  m_addr   <= d_addr;
                  m_wdata  <= d_wdata;
                  m_op     <= d_op;
               end else if (pick_i) begin
                  state    <= BUSY_I;
                  wait_cnt <= 8'd0;
                  i_gnt    <= 1'b1;
                  m_req    <= 1'b1;
                  m_we     <= 1'b0;
                  m_addr   <= i_addr;
                  m_wdata  <= 32'h0;
                  m_op     <= OP_WORD;
               end
            end
            BUSY_I, BUSY_D: begin
               if (finish) begin
                  state <= IDLE;
                  m_req <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               m_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, 255, maximum cycles a granted access may wait for m_ready before it is aborted (1..255).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_req  input  1  instruction-fetch request, held with i_addr stable until i_rvalid or i_err.
REQ-005 i_addr  input  32  fetch address.
REQ-006 i_gnt / i_rvalid / i_err  output  1 each  fetch accepted / fetch data valid / fetch timed out; each a one-cycle pulse.
REQ-007 i_rdata  output  32  fetched instruction word, valid only with i_rvalid.
REQ-008 d_req, d_we  input  1 each  load/store request held until d_rvalid or d_err; d_we=1 selects store.
REQ-009 d_addr, d_wdata  input  32 each  data address, store data.
REQ-010 d_op  input  3  access format: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-011 d_gnt / d_rvalid / d_err  output  1 each  pulses as for the fetch port.
REQ-012 d_rdata  output  32  load data; 0 when completing a store.
REQ-013 m_req, m_we  output  1 each  shared memory request / write enable.
REQ-014 m_addr, m_wdata  output  32 each  shared memory address / write data.
REQ-015 m_op  output  3  format forwarded to memory; 010 for fetches.
REQ-016 m_ready  input  1  memory completes the current access this cycle.
REQ-017 m_rdata  input  32  memory read data, valid with m_ready.

Function
REQ-018 FSM states IDLE, BUSY_I, BUSY_D; exactly one access is outstanding on the memory port at any time.
REQ-019 IDLE with any request: the winner's state is entered at the next edge, its gnt pulses in that same next cycle, and m_* are registered from the winner with m_req=1.
REQ-020 Fixed priority (macro absent): d_req beats i_req.
REQ-021 In BUSY_x with m_ready=1: x_rvalid pulses with x_rdata=m_rdata (0 for stores) in the same cycle, m_req drops at the next edge, and the FSM returns to IDLE.
REQ-022 There is exactly one IDLE bubble cycle between consecutive accesses; a new grant is issued no earlier than two cycles after the previous m_ready.
REQ-023 Wait counter (8 bit): cleared on grant; increments each BUSY cycle with m_ready=0.
REQ-024 When the counter equals TIMEOUT and m_ready=0: x_err pulses, m_req drops, FSM returns to IDLE.
REQ-025 m_ready and timeout in the same cycle: completion wins, no err.
REQ-026 A requester deasserting req while BUSY does not abort the access; the response is still issued.
REQ-027 m_addr, m_wdata, m_we and m_op stay constant for the whole of a BUSY state.
REQ-028 m_ready in IDLE is ignored.

Reset
REQ-029 rst_n low: FSM to IDLE, counter 0, round-robin pointer to "data next", and all outputs 0, immediately and independently of clk.
REQ-030 Reset during BUSY abandons the access with no rvalid or err; the requester re-requests after reset.

Configuration
REQ-031 Macro MEM_ARB_RR_EN defined: when both requests are present in IDLE, the winner alternates via a 1-bit pointer that toggles after each grant to point at the other port; a single requester always wins.
REQ-032 Macro MEM_ARB_RR_EN absent: the pointer is not present, and fixed data priority (REQ-020) applies.

Verification
REQ-033 Fetch i_addr=0x80000000, memory m_ready after 3 cycles with m_rdata=0x00100073 -> i_gnt once, m_op=010, i_rvalid once with i_rdata=0x00100073.
REQ-034 i_req and d_req asserted in the same IDLE cycle (d: load, addr 0x80001000, op 100), macro absent -> D served first, I granted 2 cycles after the D m_ready.
REQ-035 Same stimulus with MEM_ARB_RR_EN defined, repeated 4 times -> grants alternate D,I,D,I.
REQ-036 Store d_wdata=0xDEADBEEF, op 010, m_ready never asserted, TIMEOUT=4 -> d_err pulses after 4 wait cycles, m_req=0 next cycle, no d_rvalid.
REQ-037 m_ready coincident with the timeout cycle -> rvalid and no err.
REQ-038 rst_n pulsed low mid-BUSY_D -> all outputs 0 asynchronously; after release a new i_req is granted normally.
